// File: rtl/iter_mul_calc_pkg.sv
// Shared definitions for the iterative shift-add multiplier.
// Holds the FSM state encoding and the default operand width.
package iter_mul_calc_pkg;

    // Default operand width; the product is twice this wide.
    localparam int DEF_NBITS = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/iter_mul_calc_dpath.sv
// Datapath of the shift-add multiplier: a/b/acc registers, one adder
// and the iteration counter.
// Ports: clk, rst (sync, active-high); load captures in0/in1 and clears
// acc/cnt; step performs one shift (add selects acc += a on that step);
// result views acc; b_lsb, b_zero, cnt_last are status for the FSM.
module iter_mul_calc_dpath
    import iter_mul_calc_pkg::*;
#(
    parameter int nbits = DEF_NBITS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic               add,
    input  logic [nbits-1:0]   in0,
    input  logic [nbits-1:0]   in1,
    output logic [2*nbits-1:0] result,
    output logic               b_lsb,
    output logic               b_zero,
    output logic               cnt_last
);

    localparam int CW = $clog2(nbits);

    logic [2*nbits-1:0] a;
    logic [2*nbits-1:0] acc;
    logic [nbits-1:0]   b;
    logic [CW-1:0]      cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            a   <= '0;
            b   <= '0;
            acc <= '0;
            cnt <= '0;
        end else if (load) begin
            a   <= {{nbits{1'b0}}, in0};
            b   <= in1;
            acc <= '0;
            cnt <= '0;
        end else if (step) begin
            if (add) begin
                acc <= acc + a;
            end
            a   <= a << 1;
            b   <= b >> 1;
            cnt <= cnt + CW'(1);
        end
    end

    assign result   = acc;
    assign b_lsb    = b[0];
    // High when no multiplier bits remain above the one consumed this
    // cycle, i.e. b becomes zero after the current step.
    assign b_zero   = (b[nbits-1:1] == '0);
    assign cnt_last = (cnt == CW'(nbits - 1));

endmodule

// File: rtl/iter_mul_calc.sv
// Iterative shift-add unsigned multiplier with val/rdy in/out streams.
// Ports: clk, rst (sync, active-high); in0/in1 operands with
// istream_val/istream_rdy; result (2*nbits) with ostream_val/ostream_rdy.
// Optional: ITER_MUL_CALC_EARLY_EXIT_EN ends CALC once b runs out of bits.
module iter_mul_calc
    import iter_mul_calc_pkg::*;
#(
    parameter int nbits = DEF_NBITS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [nbits-1:0]   in0,
    input  logic [nbits-1:0]   in1,
    input  logic               istream_val,
    output logic               istream_rdy,
    output logic [2*nbits-1:0] result,
    output logic               ostream_val,
    input  logic               ostream_rdy
);

    state_t state;
    state_t state_nxt;

    logic load;
    logic step;
    logic b_lsb;
    logic b_zero;
    logic cnt_last;
    logic early_exit;

`ifdef ITER_MUL_CALC_EARLY_EXIT_EN
    assign early_exit = b_zero;
`else
    assign early_exit = 1'b0;
    logic unused_b_zero;
    assign unused_b_zero = b_zero;
`endif

    iter_mul_calc_dpath #(
        .nbits(nbits)
    ) u_dpath (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .step    (step),
        .add     (step & b_lsb),
        .in0     (in0),
        .in1     (in1),
        .result  (result),
        .b_lsb   (b_lsb),
        .b_zero  (b_zero),
        .cnt_last(cnt_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        unique case (state)
            IDLE: begin
                if (istream_val) begin
                    load      = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                step = 1'b1;
                if (cnt_last || early_exit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (ostream_rdy) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Handshake outputs are masked while reset is held so that nothing
    // is offered or accepted during the reset window.
    assign istream_rdy = (state == IDLE) && !rst;
    assign ostream_val = (state == DONE) && !rst;

endmodule

// File: tb/tb_iter_mul_calc.sv
// Self-checking bench for iter_mul_calc: directed and random products,
// latency, back-pressure, mid-operation reset and back-to-back ops.
module tb_iter_mul_calc;

    localparam int NB = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [NB-1:0] in0;
    logic [NB-1:0] in1;
    logic          istream_val;
    logic          istream_rdy;
    logic [2*NB-1:0] result;
    logic          ostream_val;
    logic          ostream_rdy;

    int checks = 0;
    int errors = 0;

    iter_mul_calc #(.nbits(NB)) dut (
        .clk        (clk),
        .rst        (rst),
        .in0        (in0),
        .in1        (in1),
        .istream_val(istream_val),
        .istream_rdy(istream_rdy),
        .result     (result),
        .ostream_val(ostream_val),
        .ostream_rdy(ostream_rdy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Cycles from the accept cycle to the first cycle with ostream_val.
    function automatic int exp_lat(input logic [NB-1:0] m);
`ifdef ITER_MUL_CALC_EARLY_EXIT_EN
        for (int i = NB - 1; i >= 0; i--) begin
            if (m[i]) return i + 2;
        end
        return 2;
`else
        return NB + 1;
`endif
    endfunction

    // Wait (bounded) for ostream_val; returns cycles since the accept.
    task automatic wait_done(output int n);
        n = 1;
        while (!ostream_val && n < 40) begin
            tick();
            n++;
        end
    endtask

    // Single operation: accept, latency, result, optional back-pressure,
    // handshake, return to IDLE.
    task automatic do_op(input string tag, input logic [NB-1:0] x,
                         input logic [NB-1:0] y, input int hold);
        int n;
        int w;
        longint prod;
        prod = longint'(x) * longint'(y);
        w = 0;
        while (!istream_rdy && w < 20) begin
            tick();
            w++;
        end
        chk({tag, "_rdy"}, istream_rdy, 1);
        in0 = x;
        in1 = y;
        istream_val = 1'b1;
        tick();
        istream_val = 1'b0;
        in0 = $urandom;
        in1 = $urandom;
        wait_done(n);
        chk({tag, "_lat"}, n, exp_lat(y));
        chk({tag, "_res"}, result, prod);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({tag, "_hold_val"}, ostream_val, 1);
            chk({tag, "_hold_res"}, result, prod);
            chk({tag, "_hold_irdy"}, istream_rdy, 0);
        end
        ostream_rdy = 1'b1;
        tick();
        ostream_rdy = 1'b0;
        chk({tag, "_idle_val"}, ostream_val, 0);
        chk({tag, "_idle_rdy"}, istream_rdy, 1);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        in0 = '0;
        in1 = '0;
        istream_val = 1'b0;
        ostream_rdy = 1'b0;

        // Reset with istream_val also high: reset must win.
        istream_val = 1'b1;
        tick();
        tick();
        chk("rst_irdy", istream_rdy, 0);
        chk("rst_oval", ostream_val, 0);
        chk("rst_res", result, 0);
        istream_val = 1'b0;
        rst = 1'b0;
        tick();
        chk("post_rst_irdy", istream_rdy, 1);

        do_op("basic", 8'd3, 8'd5, 0);
        do_op("max", 8'd255, 8'd255, 0);
        do_op("zero", 8'd200, 8'd0, 0);
        do_op("one", 8'd0, 8'd1, 0);
        do_op("bp", 8'd37, 8'd129, 5);

        // Reset in the middle of CALC aborts the operation.
        in0 = 8'd7;
        in1 = 8'd9;
        istream_val = 1'b1;
        tick();
        istream_val = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_irdy", istream_rdy, 0);
        chk("mid_rst_oval", ostream_val, 0);
        chk("mid_rst_res", result, 0);
        rst = 1'b0;
        ostream_rdy = 1'b1;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (ostream_val) n++;
            tick();
        end
        ostream_rdy = 1'b0;
        chk("mid_rst_no_out", n, 0);
        do_op("after_rst", 8'd2, 8'd6, 1);

        // Back-to-back with istream_val held and ostream_rdy high.
        ostream_rdy = 1'b1;
        in0 = 8'd10;
        in1 = 8'd20;
        istream_val = 1'b1;
        tick();
        wait_done(n);
        chk("b2b0_lat", n, exp_lat(8'd20));
        chk("b2b0_res", result, 200);
        in0 = 8'd13;
        in1 = 8'd11;
        tick();
        chk("b2b_gap_irdy", istream_rdy, 1);
        chk("b2b_gap_oval", ostream_val, 0);
        tick();
        istream_val = 1'b0;
        wait_done(n);
        chk("b2b1_lat", n, exp_lat(8'd11));
        chk("b2b1_res", result, 143);
        tick();
        ostream_rdy = 1'b0;
        chk("b2b_end_irdy", istream_rdy, 1);

        // Random operands against the arithmetic model.
        for (int k = 0; k < 25; k++) begin
            logic [NB-1:0] x;
            logic [NB-1:0] y;
            x = NB'($urandom);
            y = NB'($urandom);
            if (k % 5 == 0) y = NB'(y >> $urandom_range(0, NB - 1));
            do_op("rand", x, y, int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
